// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch FIFO between fetch and decode: buffers {inst, pc} pairs
// and pre-decodes the head entry's immediate field and zero/sign-extension select.
module inst_prefetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [15:0] out_imm,
    output logic        out_imm_unsign,
    input  logic        out_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [63:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic        push;
    logic        pop;
    logic        write_en;
    logic [63:0] head;
    logic [5:0]  head_opcode;

    assign in_ready  = (count_reg != FULL_COUNT);
    assign out_valid = (count_reg != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    // A word offered during a redirect or reset is dropped, never stored.
    assign write_en  = push & ~flush & ~rst;

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[wr_ptr_reg] <= {in_inst, in_pc};
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            if (push && !pop) begin
                count_next = count_reg + CNT_W'(1);
            end else if (pop && !push) begin
                count_next = count_reg - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Outputs are gated so stale or never-written array contents are never visible.
    assign head        = mem[rd_ptr_reg];
    assign head_opcode = head[63:58];

    assign out_inst       = out_valid ? head[63:32] : 32'h0;
    assign out_pc         = out_valid ? head[31:0]  : 32'h0;
    assign out_imm        = out_valid ? head[47:32] : 16'h0;
    assign out_imm_unsign = out_valid &&
                            ((head_opcode == 6'h0C) ||
                             (head_opcode == 6'h0D) ||
                             (head_opcode == 6'h0E));

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Randomized and directed checks of inst_prefetch_queue against a queue-based
// reference model of the fetch/decode buffer.
module tb_inst_prefetch_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [15:0] out_imm;
    logic        out_imm_unsign;
    logic        out_ready;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [63:0] model_q[$];
    bit          model_known = 0;

    inst_prefetch_queue #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_inst       (in_inst),
        .in_pc         (in_pc),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_inst      (out_inst),
        .out_pc        (out_pc),
        .out_imm       (out_imm),
        .out_imm_unsign(out_imm_unsign),
        .out_ready     (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected outputs follow directly from the buffered word list.
    task automatic check_outputs();
        logic [63:0] head;
        logic        exp_valid;
        logic [5:0]  opc;
        exp_valid = (model_q.size() != 0);
        head      = exp_valid ? model_q[0] : 64'h0;
        opc       = head[63:58];
        check_value("out_valid", {63'h0, out_valid}, {63'h0, exp_valid});
        check_value("in_ready", {63'h0, in_ready}, {63'h0, model_q.size() < DEPTH});
        check_value("out_inst", {32'h0, out_inst}, {32'h0, head[63:32]});
        check_value("out_pc", {32'h0, out_pc}, {32'h0, head[31:0]});
        check_value("out_imm", {48'h0, out_imm}, {48'h0, head[47:32]});
        check_value("out_imm_unsign", {63'h0, out_imm_unsign},
                    {63'h0, exp_valid && (opc inside {6'h0C, 6'h0D, 6'h0E})});
    endtask

    task automatic model_update(input logic r, input logic f, input logic iv,
                                input logic [31:0] ii, input logic [31:0] ip, input logic ordy);
        int sz;
        bit push_ok;
        bit pop_ok;
        logic [63:0] w;
        sz      = model_q.size();
        push_ok = iv && (sz < DEPTH);
        pop_ok  = ordy && (sz > 0);
        if (r || f) begin
            model_q.delete();
            if (r) model_known = 1;
            $display("[TB] %s: queue cleared", r ? "reset" : "flush");
        end else begin
            if (pop_ok) begin
                w = model_q.pop_front();
                $display("[TB] pop  inst=%08h pc=%08h", w[63:32], w[31:0]);
            end
            if (push_ok) model_q.push_back({ii, ip});
        end
    endtask

    // One clock: check current outputs, drive inputs, then advance the model.
    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [31:0] ii, input logic [31:0] ip, input logic ordy);
        @(negedge clk);
        if (model_known) check_outputs();
        rst       = r;
        flush     = f;
        in_valid  = iv;
        in_inst   = ii;
        in_pc     = ip;
        out_ready = ordy;
        @(posedge clk);
        model_update(r, f, iv, ii, ip, ordy);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, ordy);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_inst = 32'h0; in_pc = 32'h0; out_ready = 1'b0;

        // Reset, then lui followed by ori
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h3C01_1234, 32'h0040_0000, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h3421_8000, 32'h0040_0004, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);

        // Fill to DEPTH, offer one more, drain in order
        for (int i = 0; i < DEPTH + 1; i++)
            step(1'b0, 1'b0, 1'b1, 32'h2000_0000 | 32'(i), 32'(i * 4), 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

        // Streaming across pointer wrap
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'b0, 1'b1, $urandom, 32'h0040_1000 + 32'(i * 4), 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Flush with three entries held, concurrent push and pop
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'b1, $urandom, 32'h0040_2000 + 32'(i * 4), 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0040_200C, 1'b1);
        step(1'b0, 1'b0, 1'b1, 32'h3042_00FF, 32'h0040_0100, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // Reset while full, hold it, then resume
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, 1'b0, 1'b1, $urandom, 32'h0040_3000 + 32'(i * 4), 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h1111_1111, 32'h0040_3010, 1'b1);
        step(1'b1, 1'b0, 1'b1, 32'h2222_2222, 32'h0040_3014, 1'b1);
        step(1'b0, 1'b0, 1'b1, 32'h3333_3333, 32'h0040_3018, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h3444_4444, 32'h0040_301C, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Opcode sweep 0x08..0x0F through the head
        for (int op = 8; op < 16; op++)
            step(1'b0, 1'b0, 1'b1, {6'(op), 26'($urandom)}, 32'h0040_4000 + 32'(op * 4), 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Random traffic with occasional redirects and resets
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] word;
            word = $urandom;
            if ($urandom_range(0, 3) == 0) word[31:26] = 6'($urandom_range(8, 15));
            step($urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 9) < 7, word, $urandom, $urandom_range(0, 9) < 6);
        end
        idle(1'b1);
        idle(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
